// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit adder reusing one 4-bit ripple-carry slice, LSB nibble first.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    operand handshake for a, b, c_in
//   a, b, c_in           W-bit operands and carry into the least significant nibble
//   out_valid/out_ready  result handshake for sum, c_out
//   sum, c_out           registered W-bit sum and carry out of the top nibble
//   busy                 high while an operation is in flight or awaiting hand-off
//   ovf                  signed overflow flag, present only with NIBBLE_ADDER_OVF_EN defined
// Optional feature macro: NIBBLE_ADDER_OVF_EN

module rca4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c3_o,
    output logic       c_o
);
    logic [4:0] c;
    assign c[0] = c_i;
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    // carry into bit 3 feeds the signed overflow detection of the top nibble
    assign c3_o = c[3];
    assign c_o  = c[4];
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 c_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 c_out,
`ifdef NIBBLE_ADDER_OVF_EN
    output logic                 ovf,
`endif
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          c_out_q, c_out_d;
    logic [3:0]    s;
    logic          s_c3, s_co;
    logic          last;
`ifdef NIBBLE_ADDER_OVF_EN
    logic          ovf_q, ovf_d;
    assign ovf = ovf_q;
`endif

    rca4 u_slice (
        .a_i  (a_q[{idx_q, 2'b00} +: 4]),
        .b_i  (b_q[{idx_q, 2'b00} +: 4]),
        .c_i  (carry_q),
        .s_o  (s),
        .c3_o (s_c3),
        .c_o  (s_co)
    );

    assign last      = idx_q == IW'(NIBBLES - 1);
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = !in_ready;
    assign sum       = sum_q;
    assign c_out     = c_out_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
`ifdef NIBBLE_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (state_q == IDLE && in_valid) begin
            a_d     = a;
            b_d     = b;
            carry_d = c_in;
            sum_d   = '0;
            idx_d   = '0;
            state_d = ADD;
        end else if (state_q == ADD) begin
            sum_d[{idx_q, 2'b00} +: 4] = s;
            carry_d = s_co;
            idx_d   = last ? idx_q : idx_q + 1'b1;
            if (last) begin
                c_out_d = s_co;
`ifdef NIBBLE_ADDER_OVF_EN
                ovf_d   = s_c3 ^ s_co;
`endif
                state_d = DONE;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
`ifdef NIBBLE_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
`ifdef NIBBLE_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

`ifndef NIBBLE_ADDER_OVF_EN
    logic unused;
    assign unused = s_c3;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed table-driven bench for nibble_serial_adder (NIBBLES=4).
module tb_nibble_serial_adder;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        c_out;
    logic        busy;
`ifdef NIBBLE_ADDER_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
`ifdef NIBBLE_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        @(negedge clk);
        a = av;
        b = bv;
        c_in = cv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("accept_in_ready", in_ready, 0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        launch(v.a, v.b, v.cin);
        in_valid = 1'b0;
        a = ~v.a;
        b = ~v.b;
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            #1;
            chk({nm, "_latency"}, out_valid, k == N);
        end
        chk({nm, "_sum"}, sum, v.sum);
        chk({nm, "_cout"}, c_out, v.cout);
`ifdef NIBBLE_ADDER_OVF_EN
        chk({nm, "_ovf"}, ovf, v.ovf);
`endif
        @(posedge clk);
        #1;
        chk({nm, "_idle"}, in_ready, 1);
        chk({nm, "_sum_kept"}, sum, v.sum);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{16'h0003, 16'h0009, 1'b0, 16'h000C, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h5555, 16'h5555, 1'b0, 16'hAAAA, 1'b0, 1'b1};
        vecs[8] = '{16'hA5C3, 16'h5A3C, 1'b1, 16'h0000, 1'b1, 1'b0};

        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", c_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // backpressure: hold DONE for 5 cycles
        out_ready = 1'b0;
        launch(16'h1234, 16'h1111, 1'b0);
        in_valid = 1'b0;
        repeat (N) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_sum", sum, 16'h2345);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);

        // in_valid held during ADD with new operands is ignored
        launch(16'h1234, 16'h0001, 1'b0);
        a = 16'hAAAA;
        b = 16'h0000;
        chk("ign_sum_cleared", sum, 0);
        repeat (N) @(posedge clk);
        #1;
        chk("ign_first_valid", out_valid, 1);
        chk("ign_first_sum", sum, 16'h1235);
        @(posedge clk);
        #1;
        chk("ign_back_idle", in_ready, 1);
        @(posedge clk);
        #1;
        chk("ign_second_accept", in_ready, 0);
        in_valid = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        chk("ign_second_sum", sum, 16'hAAAA);
        chk("ign_second_cout", c_out, 0);
        @(posedge clk);
        #1;

        // reset in the 2nd ADD cycle aborts the operation
        launch(16'h00FF, 16'h0001, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", c_out, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N + 1; k++) begin
            @(posedge clk);
            #1;
            chk("abort_no_valid", out_valid, 0);
        end
        run_vec('{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0}, "fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-word adder that accepts wide operands and reuses one 4-bit ripple-carry slice, one nibble per cycle, LSB nibble first.
- The carry between nibbles is held in a register.
- Sits between an operand source and a result consumer, with valid/ready handshakes on both sides.
- The team's existing 4-bit ripple-carry adder is the slice instantiated inside this block.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand source has a, b, c_in valid.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- c_in  input  1  carry into the least significant nibble.
- out_valid  output  1  sum and c_out are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  registered sum.
- c_out  output  1  registered carry out of the most significant nibble.
- busy  output  1  high in ADD or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, nibble index idx=0, carry reg=0.
  - Operand regs=0, sum=0, c_out=0, out_valid=0.
  - in_ready follows state, so it is 1 while in reset; any transfer during reset is ignored.
- Combinational outputs: in_ready = (state==IDLE); out_valid = (state==DONE); busy = !in_ready.
- IDLE:
  - On in_valid && in_ready at a rising edge: capture a, b, and c_in into the carry reg; clear sum to 0; set idx=0; go to ADD.
- ADD, each cycle:
  - Slice adds a_reg[4*idx+:4] + b_reg[4*idx+:4] + carry.
  - sum[4*idx+:4] <= slice sum; carry <= slice carry out.
  - If idx==NIBBLES-1: c_out <= slice carry out; go to DONE. Otherwise idx <= idx+1.
- DONE:
  - Hold sum and c_out stable.
  - On out_ready: go to IDLE; sum and c_out keep their values until the next capture.
- Latency: accept edge to out_valid high is exactly NIBBLES cycles.
- Throughput: one operation per NIBBLES+2 cycles minimum. There is no overlap, because in_ready is low in DONE.
- in_valid in ADD or DONE is ignored. a, b and c_in may change freely after capture without affecting the result.
- out_ready while out_valid is low has no effect.
- Backpressure: DONE may be held indefinitely; sum and c_out must not change while out_valid=1 && !out_ready.
- Arithmetic is unsigned modulo 2^W; {c_out,sum} equals a+b+c_in exactly.
- Reset mid-operation (in ADD or DONE) aborts immediately to the reset values; the result is discarded and no out_valid pulse occurs.
- Internal idx width is clog2(NIBBLES); idx never exceeds NIBBLES-1.

Optional Feature:
- Macro: NIBBLE_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow flag.
  - ovf = carry into MSB bit XOR carry out of MSB bit, computed within the last nibble (the carry out of slice bit 2 XOR the final c_out).
  - ovf is registered with c_out, valid with out_valid, and reset to 0.
- When undefined: no ovf port, no extra logic; all other behaviour is identical.

Test Plan:
- NIBBLES=4, a=0x0003, b=0x0009, c_in=0, out_ready=1 -> out_valid rises exactly 4 cycles after the accept edge; sum=0x000C, c_out=0.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1. Checks that the carry ripples across all 4 cycles.
- a=0x8000, b=0x8000, c_in=1 -> sum=0x0001, c_out=1; ovf=1 when NIBBLE_ADDER_OVF_EN is defined. Also a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, ovf=1.
- Backpressure: a=0x1234, b=0x1111; hold out_ready=0 for 5 cycles in DONE -> sum=0x2345 stays stable and in_ready=0 throughout. After out_ready=1, in_ready=1 the next cycle.
- in_valid held high with new operands (a=0xAAAA) while in ADD -> ignored; the first result is unchanged and the second operation starts only after returning to IDLE.
- Pulse rst_n low at the 2nd ADD cycle of a=0x00FF, b=0x0001 -> out_valid=0, sum=0, c_out=0, in_ready=1 immediately. A fresh operation afterwards (0x00FF+0x0001) gives 0x0100.
